// File: rtl/de0_sw_debounce_if.sv
// Switch-conditioning bus: raw pins in, debounced level and change strobes out.
// The master drives the raw pins; the debouncer is the slave.
interface de0_sw_debounce_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] sw_change;
    logic             any_change;

    modport master (
        output sw_raw,
        input  sw_clean,
        input  sw_change,
        input  any_change
    );

    modport slave (
        input  sw_raw,
        output sw_clean,
        output sw_change,
        output any_change
    );
endinterface

// File: rtl/de0_sw_debounce.sv
// Per-bit two-flop synchroniser plus stability-counter debouncer for DE0 switches/buttons.
// Optional build macro SW_DEBOUNCE_ACTIVE_LOW_EN inverts the pins so a pressed button reads 1.
module de0_sw_debounce #(
    parameter int WIDTH           = 4,
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              reset_n,
    de0_sw_debounce_if.slave  bus
);
    typedef enum logic {STABLE, CHECK} state_t;

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] clean_vec;
    logic [WIDTH-1:0] change_vec;
    logic [WIDTH-1:0] fire;
    logic             any_change_reg;

`ifdef SW_DEBOUNCE_ACTIVE_LOW_EN
    assign raw_in = ~bus.sw_raw;
`else
    assign raw_in = bus.sw_raw;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            state_t           state_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             clean_reg;
            logic             change_reg;

            // Terminal compare: the sample at this edge still differs, so the new level is accepted.
            assign fire[gi] = (state_reg == CHECK) && (sync2_reg[gi] != clean_reg) && (cnt_reg == TERM);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_reg  <= STABLE;
                    cnt_reg    <= '0;
                    clean_reg  <= 1'b0;
                    change_reg <= 1'b0;
                end else begin
                    change_reg <= fire[gi];
                    case (state_reg)
                        STABLE: begin
                            cnt_reg <= '0;
                            if (sync2_reg[gi] != clean_reg) begin
                                state_reg <= CHECK;
                            end
                        end
                        CHECK: begin
                            if (sync2_reg[gi] == clean_reg) begin
                                state_reg <= STABLE;
                                cnt_reg   <= '0;
                            end else if (cnt_reg == TERM) begin
                                clean_reg <= sync2_reg[gi];
                                state_reg <= STABLE;
                                cnt_reg   <= '0;
                            end else begin
                                cnt_reg <= cnt_reg + CNT_W'(1);
                            end
                        end
                        default: begin
                            state_reg <= STABLE;
                            cnt_reg   <= '0;
                        end
                    endcase
                end
            end

            assign clean_vec[gi]  = clean_reg;
            assign change_vec[gi] = change_reg;
        end
    endgenerate

    // Registered alongside the per-bit strobes so both appear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            any_change_reg <= 1'b0;
        end else begin
            any_change_reg <= |fire;
        end
    end

    assign bus.sw_clean   = clean_vec;
    assign bus.sw_change  = change_vec;
    assign bus.any_change = any_change_reg;
endmodule

// File: tb/tb_de0_sw_debounce.sv
// Bench for de0_sw_debounce: run-length reference model checked every cycle, plus directed literal checks.
// Also covers the SW_DEBOUNCE_ACTIVE_LOW_EN build when that macro is defined.
module tb_de0_sw_debounce;
    localparam int W = 4;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   cmp_en = 1'b0;

    de0_sw_debounce_if #(.WIDTH(W)) bus ();

    de0_sw_debounce #(.WIDTH(W), .CNT_W(8), .DEBOUNCE_CYCLES(D)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference: a bit toggles once D+1 consecutive synchronised samples disagree with its clean level.
    logic [W-1:0] m_s1, m_s2, m_clean, m_change, raw_eff;
    logic         m_any;
    int           run [W];

`ifdef SW_DEBOUNCE_ACTIVE_LOW_EN
    assign raw_eff = ~bus.sw_raw;
`else
    assign raw_eff = bus.sw_raw;
`endif

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0; m_change = '0; m_any = 1'b0;
            for (int i = 0; i < W; i++) run[i] = 0;
        end else begin
            m_change = '0;
            for (int i = 0; i < W; i++) begin
                if (m_s2[i] != m_clean[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] == D + 1) begin
                        m_clean[i]  = ~m_clean[i];
                        m_change[i] = 1'b1;
                        run[i]      = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_any = |m_change;
            m_s2  = m_s1;
            m_s1  = raw_eff;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_clean", 32'(bus.sw_clean), 32'(m_clean));
            chk("cyc_change", 32'(bus.sw_change), 32'(m_change));
            chk("cyc_any", 32'(bus.any_change), 32'(m_any));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives the logical (pressed = 1) level, so expectations are the same in both builds.
    task automatic set_raw(input logic [W-1:0] v);
`ifdef SW_DEBOUNCE_ACTIVE_LOW_EN
        bus.sw_raw = ~v;
`else
        bus.sw_raw = v;
`endif
    endtask

    task automatic count_pulses(input int bitn, input int cycles, output int pulses, output int toggles);
        logic prev;
        pulses  = 0;
        toggles = 0;
        prev    = bus.sw_clean[bitn];
        for (int c = 0; c < cycles; c++) begin
            tick(1);
            if (bus.sw_change[bitn]) pulses++;
            if (bus.sw_clean[bitn] != prev) toggles++;
            prev = bus.sw_clean[bitn];
        end
    endtask

    int pulses, toggles;
    logic [W-1:0] cur;

    initial begin
        set_raw(4'b0000);
        cmp_en = 1'b1;
        tick(3);
        chk("rst_clean", 32'(bus.sw_clean), 32'h0);
        chk("rst_any", 32'(bus.any_change), 32'h0);
        reset_n = 1'b1;
        tick(50);
        chk("idle_clean", 32'(bus.sw_clean), 32'h0);
        $display("txn idle: clean=%b change=%b", bus.sw_clean, bus.sw_change);

        // Clean step on bit 0: lands at edge D+3 = 7.
        cur = 4'b0001; set_raw(cur);
        tick(6);
        chk("step_e6_clean", 32'(bus.sw_clean), 32'h0);
        tick(1);
        chk("step_e7_clean", 32'(bus.sw_clean), 32'h1);
        chk("step_e7_change", 32'(bus.sw_change), 32'h1);
        chk("step_e7_any", 32'(bus.any_change), 32'h1);
        chk("model_e7_clean", 32'(m_clean), 32'h1);
        tick(1);
        chk("step_e8_change", 32'(bus.sw_change), 32'h0);
        chk("step_e8_any", 32'(bus.any_change), 32'h0);
        count_pulses(0, 20, pulses, toggles);
        chk("step_no_more", 32'(pulses), 32'h0);
        $display("txn step: clean=%b", bus.sw_clean);

        // Asynchronous reset mid-run clears outputs before the next edge.
        #2 reset_n = 1'b0;
        #1 chk("async_clean", 32'(bus.sw_clean), 32'h0);
        chk("async_change", 32'(bus.sw_change), 32'h0);
        tick(1);
        #2 reset_n = 1'b1;
        tick(20);
        chk("requal_clean", 32'(bus.sw_clean), 32'h1);
        $display("txn async reset: clean=%b", bus.sw_clean);

        // Bounce on bit 1, then steady high.
        for (int k = 0; k < 4; k++) begin
            cur[1] = (k % 2 == 0); set_raw(cur);
            tick(2);
        end
        cur[1] = 1'b1; set_raw(cur);
        count_pulses(1, 20, pulses, toggles);
        chk("bounce_pulses", 32'(pulses), 32'h1);
        chk("bounce_toggles", 32'(toggles), 32'h1);
        chk("bounce_clean", 32'(bus.sw_clean), 32'h3);
        $display("txn bounce: clean=%b pulses=%0d", bus.sw_clean, pulses);

        // Glitch on bit 2 shorter than the qualification window.
        cur[2] = 1'b1; set_raw(cur);
        tick(3);
        cur[2] = 1'b0; set_raw(cur);
        count_pulses(2, 20, pulses, toggles);
        chk("glitch_pulses", 32'(pulses), 32'h0);
        chk("glitch_clean", 32'(bus.sw_clean), 32'h3);
        $display("txn glitch: clean=%b", bus.sw_clean);

        // Simultaneous transitions settle together.
        cur = 4'b0000; set_raw(cur);
        tick(20);
        cur = 4'b1010; set_raw(cur);
        tick(6);
        chk("simul_e6_clean", 32'(bus.sw_clean), 32'h0);
        tick(1);
        chk("simul_clean", 32'(bus.sw_clean), 32'hA);
        chk("simul_change", 32'(bus.sw_change), 32'hA);
        chk("simul_any", 32'(bus.any_change), 32'h1);
        tick(1);
        chk("simul_any_off", 32'(bus.any_change), 32'h0);
        $display("txn simultaneous: clean=%b", bus.sw_clean);

        // Reset mid-count on bit 3 aborts, then re-qualifies from release.
        cur = 4'b0000; set_raw(cur);
        tick(20);
        cur = 4'b1000; set_raw(cur);
        tick(5);
        #2 reset_n = 1'b0;
        #1 chk("midcnt_change", 32'(bus.sw_change), 32'h0);
        tick(1);
        #2 reset_n = 1'b1;
        count_pulses(3, 6, pulses, toggles);
        chk("midcnt_nopulse", 32'(pulses), 32'h0);
        chk("midcnt_e6_clean", 32'(bus.sw_clean), 32'h0);
        tick(1);
        chk("midcnt_e7_clean", 32'(bus.sw_clean), 32'h8);
        chk("midcnt_e7_change", 32'(bus.sw_change), 32'h8);
        $display("txn reset mid-count: clean=%b", bus.sw_clean);

`ifdef SW_DEBOUNCE_ACTIVE_LOW_EN
        // Physical pin levels: released buttons read high.
        bus.sw_raw = 4'b1111;
        tick(30);
        chk("al_released", 32'(bus.sw_clean), 32'h0);
        bus.sw_raw = 4'b1110;
        tick(6);
        chk("al_e6", 32'(bus.sw_clean), 32'h0);
        tick(1);
        chk("al_pressed", 32'(bus.sw_clean), 32'h1);
        $display("txn active-low: clean=%b", bus.sw_clean);
`endif

        tick(5);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/de0_sw_debounce.md
Name: de0_sw_debounce

Overview:
- Conditions raw DE0 slide-switch/pushbutton pins before they reach the switch PIO's `in_port` input.
- Per bit: two-flop synchroniser, then a stability counter. The output updates only after the input has held a new level for `DEBOUNCE_CYCLES` consecutive clocks.
- Also emits a one-cycle change strobe per bit, for an interrupt or edge-capture stage.
- Sits between the FPGA pins and the Qsys system, inside the top-level wrapper.

Parameters:
- WIDTH, 4, number of switch bits (matches the PIO `in_port` width).
- CNT_W, 20, stability counter width; `2^CNT_W` must exceed `DEBOUNCE_CYCLES`.
- DEBOUNCE_CYCLES, 500000, stable clocks required (10 ms at 50 MHz); legal range 2..`2^CNT_W-1`.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  reset; asynchronous assert, active low.
- sw_raw  in  WIDTH  asynchronous switch pins.
- sw_clean  out  WIDTH  debounced level; drives the PIO `in_port`.
- sw_change  out  WIDTH  one-cycle pulse per bit when that bit's `sw_clean` toggles.
- any_change  out  1  OR-reduction of `sw_change`, registered in the same cycle as `sw_change`.

Behaviour:
- Clocking and reset:
  - Single clock domain, clock `clk`, reset `reset_n`. Reset is asynchronous and active-low.
  - While `reset_n`=0, all flops clear: `sync1`, `sync2`, `sw_clean`, `sw_change`, `any_change` = 0; every counter = 0; every bit FSM = STABLE.
  - Reset asserted mid-count aborts the count; no pulse is produced.
- Synchroniser:
  - `sync1` <= `sw_raw`; `sync2` <= `sync1`.
  - Only `sync2` feeds the FSMs. `sw_raw` is never used combinationally.
- Per-bit FSM (WIDTH independent copies, each with its own counter):
  - STABLE:
    - If `sync2[i]` != `sw_clean[i]`: go to CHECK, cnt <= 0.
    - Otherwise stay; cnt held at 0.
  - CHECK:
    - If `sync2[i]` == `sw_clean[i]`: glitch rejected; go to STABLE, cnt <= 0, no pulse.
    - Else if cnt == `DEBOUNCE_CYCLES-1`: `sw_clean[i]` <= `sync2[i]`, `sw_change[i]` <= 1, go to STABLE, cnt <= 0.
    - Else cnt <= cnt+1.
- Latency:
  - A clean step on `sw_raw[i]` first sampled at edge 1 appears on `sw_clean[i]` after edge `DEBOUNCE_CYCLES+3`.
  - `sw_change[i]` is high for exactly the cycle following that edge.
- `sw_change`:
  - Pulse width is exactly one clock, then deasserts.
  - Back-to-back pulses on the same bit are impossible: at least `DEBOUNCE_CYCLES+1` cycles separate them.
- Counter:
  - Unsigned.
  - Never wraps: the terminal compare at `DEBOUNCE_CYCLES-1` always fires first.
- Bit independence:
  - Bits are fully independent.
  - Simultaneous transitions on several bits that all settle together give simultaneous `sw_change` bits and a single `any_change` cycle.
- Power-up with a switch held high:
  - After reset release, `sw_clean` reads 0.
  - It goes to 1 after `DEBOUNCE_CYCLES+3` cycles, with a `sw_change` pulse.
  - Software must tolerate this.
- Bounce ending exactly on the terminal cycle: the sample at the compare edge decides. If `sync2` still differs, the update happens.

Optional Feature:
- Macro: `SW_DEBOUNCE_ACTIVE_LOW_EN`.
- Defined:
  - `sw_raw` is inverted before `sync1`. DE0 pushbuttons are active-low, so a pressed button reads 1 on `sw_clean`.
  - Reset values are still 0 (not pressed); flops reset to 0 after the inverter.
- Undefined: no inversion; `sw_raw` level passes straight through.
- Ports, latency and all other behaviour are identical in both builds.

Test Plan:
- Reset, then `sw_raw`=4'b0000 held, `DEBOUNCE_CYCLES`=4:
  - `sw_clean`=0, `sw_change`=0, `any_change`=0 for 50 cycles.
  - Assert `reset_n` low mid-run: all outputs 0 asynchronously, before the next edge.
- Clean step `sw_raw[0]` 0->1 with `DEBOUNCE_CYCLES`=4:
  - `sw_clean[0]`=1 after edge 7 counted from the first sampling edge.
  - `sw_change`=4'b0001 and `any_change`=1 for exactly one cycle.
  - No further pulses.
- Bounce on `sw_raw[1]`: 1,0,1,0 each held 2 cycles, then 1 held steady (`DEBOUNCE_CYCLES`=4):
  - No intermediate `sw_clean` change.
  - A single pulse after the final level has been stable 4 cycles.
- Glitch: `sw_raw[2]` high for 3 cycles then back low (`DEBOUNCE_CYCLES`=4):
  - `sw_clean[2]` stays 0; `sw_change` stays 0.
- Simultaneous: `sw_raw` 4'b0000 -> 4'b1010 on one edge:
  - `sw_clean`=4'b1010 on the same cycle.
  - `sw_change`=4'b1010 and `any_change`=1 for one cycle.
- Reset mid-count, then macro build:
  - Step `sw_raw[3]` to 1, pulse `reset_n` low at count 2, release: no pulse occurs before re-qualification, then `sw_clean[3]`=1 `DEBOUNCE_CYCLES+3` cycles after reset release.
  - With `SW_DEBOUNCE_ACTIVE_LOW_EN` defined, `sw_raw`=4'b1111 after reset gives `sw_clean`=0 permanently; `sw_raw[0]`=0 gives `sw_clean[0]`=1.
